// File: rtl/pll_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
package pll_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILISE = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int unsigned DefPllRstCycles     = 16;
  localparam int unsigned DefLockStableCycles = 1024;
  localparam int unsigned DefRelockTimeout    = 65536;
  localparam int unsigned DefSyncStages       = 2;

  // Width that holds the largest of the three cycle limits.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser with asynchronous active-low reset.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Turns an asynchronous PLL lock flag into a qualified system reset and ready flag,
// pulsing the PLL reset when relock takes too long.
module pll_lock_supervisor
  import pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES     = DefPllRstCycles,
  parameter int unsigned LOCK_STABLE_CYCLES = DefLockStableCycles,
  parameter int unsigned RELOCK_TIMEOUT     = DefRelockTimeout,
  parameter int unsigned SYNC_STAGES        = DefSyncStages
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       sys_ready,
  output logic       lost_lock,
  output logic [7:0] loss_count
);

  localparam int unsigned CntW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, RELOCK_TIMEOUT);
  localparam logic [CntW-1:0] RstLast     = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(RELOCK_TIMEOUT - 1);

  pll_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            locked_s;
  logic            lost_d;
  logic [7:0]      loss_count_q, loss_count_d;
  logic            pll_rst_q, sys_reset_q, sys_ready_q, lost_lock_q;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (refclk),
    .rst_ni(rst_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    unique case (state_q)
      PLL_RESET: begin
        if (cnt_q == RstLast) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_d = STABILISE;
        end else if (cnt_q == TimeoutLast) begin
          state_d = PLL_RESET;
        end
      end
      STABILISE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == StableLast) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) state_d = WAIT_LOCK;
      end
      default: state_d = PLL_RESET;
    endcase
    if (state_d != state_q) cnt_d = '0;

    lost_d       = (state_q == RUN) && (state_d != RUN);
    loss_count_d = loss_count_q;
    if (lost_d && (loss_count_q != 8'hFF)) loss_count_d = loss_count_q + 8'd1;
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PLL_RESET;
      cnt_q        <= '0;
      loss_count_q <= '0;
      pll_rst_q    <= 1'b1;
      sys_reset_q  <= 1'b1;
      sys_ready_q  <= 1'b0;
      lost_lock_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      loss_count_q <= loss_count_d;
      pll_rst_q    <= (state_d == PLL_RESET);
      sys_reset_q  <= (state_d != RUN);
      sys_ready_q  <= (state_d == RUN);
      lost_lock_q  <= lost_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_reset  = sys_reset_q;
  assign sys_ready  = sys_ready_q;
  assign lost_lock  = lost_lock_q;
  assign loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a per-cycle phase model feeds an expectation
// queue that a negedge monitor drains, plus directed timing checks.
module tb_pll_lock_supervisor;

  localparam int RstCyc    = 4;
  localparam int StableCyc = 8;
  localparam int Timeout   = 32;
  localparam int Stages    = 2;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_reset, sys_ready, lost_lock;
  logic [7:0] loss_count;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES    (RstCyc),
    .LOCK_STABLE_CYCLES(StableCyc),
    .RELOCK_TIMEOUT    (Timeout),
    .SYNC_STAGES       (Stages)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_reset (sys_reset),
    .sys_ready (sys_ready),
    .lost_lock (lost_lock),
    .loss_count(loss_count)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic       pll_rst;
    logic       sys_reset;
    logic       sys_ready;
    logic       lost_lock;
    logic [7:0] loss_count;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;

  // Behavioural model: phase plus time spent in it, lock seen through a delay line.
  typedef enum int {MRst, MWait, MStab, MRun} mphase_e;
  mphase_e m_phase;
  int      m_elapsed;
  int      m_losses;
  bit      m_pulse;
  bit      m_hist[Stages];

  function automatic void model_reset();
    m_phase   = MRst;
    m_elapsed = 0;
    m_losses  = 0;
    m_pulse   = 1'b0;
    for (int i = 0; i < Stages; i++) m_hist[i] = 1'b0;
  endfunction

  function automatic void enter(input mphase_e p);
    m_phase   = p;
    m_elapsed = 0;
  endfunction

  function automatic void model_edge(input bit lk);
    bit seen;
    seen = m_hist[Stages-1];
    for (int i = Stages - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = lk;
    m_pulse = 1'b0;
    case (m_phase)
      MRst: begin
        m_elapsed++;
        if (m_elapsed == RstCyc) enter(MWait);
      end
      MWait: begin
        if (seen) enter(MStab);
        else begin
          m_elapsed++;
          if (m_elapsed == Timeout) enter(MRst);
        end
      end
      MStab: begin
        if (!seen) enter(MWait);
        else begin
          m_elapsed++;
          if (m_elapsed == StableCyc) enter(MRun);
        end
      end
      default: begin
        if (!seen) begin
          enter(MWait);
          m_pulse = 1'b1;
          if (m_losses < 255) m_losses++;
        end
      end
    endcase
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.pll_rst    = (m_phase == MRst);
    e.sys_reset  = (m_phase != MRun);
    e.sys_ready  = (m_phase == MRun);
    e.lost_lock  = m_pulse;
    e.loss_count = 8'(m_losses);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step(input bit lk);
    pll_locked = lk;
    @(posedge refclk);
    #1;
    model_edge(lk);
    exp_q.push_back(model_exp());
    edge_n++;
  endtask

  task automatic do_reset();
    @(negedge refclk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_outputs", int'({pll_rst, sys_reset, sys_ready, lost_lock, loss_count}),
          int'({1'b1, 1'b1, 1'b0, 1'b0, 8'd0}));
    @(posedge refclk);
    @(negedge refclk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  // Monitor: outputs are live every cycle, so one expectation is consumed per negedge.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge refclk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pll_rst, sys_reset, sys_ready, lost_lock, loss_count};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got rst=%b sysrst=%b rdy=%b lost=%b cnt=%0d, expected rst=%b sysrst=%b rdy=%b lost=%b cnt=%0d",
                   $time, act.pll_rst, act.sys_reset, act.sys_ready, act.lost_lock,
                   act.loss_count, e.pll_rst, e.sys_reset, e.sys_ready, e.lost_lock,
                   e.loss_count);
        end
      end
    end
  end

  initial begin
    int fall, rise, pulses, rises1, rises2, ever_low, prev, t;
    model_reset();

    // 1: lock held from reset release.
    pll_locked = 1'b1;
    do_reset();
    fall = -1; rise = -1; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      if (fall < 0 && !pll_rst) fall = edge_n;
      if (rise < 0 && sys_ready) rise = edge_n;
      pulses += int'(lost_lock);
    end
    check("t1_pll_rst_fall_edge", fall, 4);
    check("t1_ready_edge", rise, 13);
    check("t1_no_lost_lock", pulses, 0);

    // 2: never locks, periodic PLL reset.
    pll_locked = 1'b0;
    do_reset();
    rises1 = -1; rises2 = -1; ever_low = 0; prev = 1;
    for (int i = 0; i < 80; i++) begin
      step(1'b0);
      if (pll_rst && prev == 0) begin
        if (rises1 < 0) rises1 = edge_n;
        else if (rises2 < 0) rises2 = edge_n;
      end
      prev = int'(pll_rst);
      if (!sys_reset) ever_low = 1;
    end
    check("t2_first_repulse", rises1, 36);
    check("t2_second_repulse", rises2, 72);
    check("t2_sys_reset_held", ever_low, 0);
    check("t2_loss_count", int'(loss_count), 0);

    // 3: lock loss in RUN.
    pll_locked = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1);
    rise = -1; pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      step(1'b0);
      if (rise < 0 && sys_reset) rise = i;
      pulses += int'(lost_lock);
    end
    check("t3_sys_reset_delay", rise, 3);
    rise = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      if (rise < 0 && sys_ready) rise = i;
      pulses += int'(lost_lock);
    end
    check("t3_ready_return", rise, 11);
    check("t3_lost_pulses", pulses, 1);
    check("t3_loss_count", int'(loss_count), 1);

    // 4: drop during stabilisation at stable-count 6.
    pll_locked = 1'b1;
    do_reset();
    rise = -1;
    for (int i = 1; i <= 30; i++) begin
      step((i == 10 || i == 11) ? 1'b0 : 1'b1);
      if (rise < 0 && sys_ready) rise = edge_n;
    end
    check("t4_ready_delayed", rise, 22);

    // 5: saturation of the loss counter.
    pll_locked = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1);
    pulses = 0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b0);
        pulses += int'(lost_lock);
      end
      for (int i = 0; i < 12; i++) step(1'b1);
    end
    check("t5_lost_pulses", pulses, 300);
    check("t5_loss_saturated", int'(loss_count), 255);

    // 6: reset from RUN, then from mid PLL reset.
    do_reset();
    fall = -1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      if (fall < 0 && !pll_rst) fall = edge_n;
    end
    check("t6_run_reset_pll_rst_len", fall, 4);
    check("t6_run_reset_loss_cleared", int'(loss_count), 0);
    do_reset();
    step(1'b1);
    step(1'b1);
    do_reset();
    fall = -1; rise = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      if (fall < 0 && !pll_rst) fall = edge_n;
      if (rise < 0 && sys_ready) rise = edge_n;
    end
    check("t6_mid_reset_pll_rst_len", fall, 4);
    check("t6_mid_reset_ready_edge", rise, 13);

    // Random lock/unlock segments, checked cycle by cycle against the model.
    do_reset();
    t = 0;
    while (t < 1500) begin
      if ($urandom_range(0, 3) != 0) begin
        int len = $urandom_range(1, 40);
        for (int i = 0; i < len; i++) step(1'b1);
        t += len;
      end else begin
        int len = $urandom_range(1, 45);
        for (int i = 0; i < len; i++) step(1'b0);
        t += len;
      end
    end

    @(negedge refclk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
